// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with registered results and flags.
// Non-MUL ops complete in one cycle; MUL is a WIDTH-step shift-and-add.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake; in_ctl, in_a, in_b, in_tag request
//   out_valid/out_ready result handshake; out_result, out_tag result
//   out_zero/out_neg/out_carry/out_ovf/out_illegal  result flags
module alu_seq #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned TAG_W  = 4,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_ctl,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = SHW + 1;

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, acc;
   logic [TAG_W-1:0] mtag;

   logic [WIDTH-1:0] res_c;
   logic [WIDTH:0]   sum_c;
   logic [SHW-1:0]   shamt;
   logic             carry_c, ovf_c, ill_c, is_mul, accept, mul_done;

   // Single-cycle datapath for everything except MUL.
   always_comb begin
      res_c   = '0;
      sum_c   = '0;
      carry_c = 1'b0;
      ovf_c   = 1'b0;
      ill_c   = 1'b0;
      shamt   = in_b[SHW-1:0];
      case (in_ctl)
         4'b0000: res_c = in_a & in_b;
         4'b0001: res_c = in_a | in_b;
         4'b0010: begin
            sum_c   = {1'b0, in_a} + {1'b0, in_b};
            res_c   = sum_c[WIDTH-1:0];
            carry_c = sum_c[WIDTH];
            ovf_c   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res_c[WIDTH-1] != in_a[WIDTH-1]);
         end
         4'b0011: res_c = in_a ^ in_b;
         4'b0100: res_c = in_a << shamt;
         4'b0101: res_c = in_a >> shamt;
         4'b0110: begin
            // Subtract as A + ~B + 1 so carry-out means "no borrow".
            sum_c   = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
            res_c   = sum_c[WIDTH-1:0];
            carry_c = sum_c[WIDTH];
            ovf_c   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res_c[WIDTH-1] != in_a[WIDTH-1]);
         end
         4'b0111: res_c = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         4'b1000: res_c = $signed(in_a) >>> shamt;
         4'b1001: res_c = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
         4'b1011: ill_c = !MUL_EN;
         4'b1100: res_c = ~(in_a | in_b);
         default: ill_c = 1'b1;
      endcase
   end

   assign is_mul   = (in_ctl == 4'b1011) && MUL_EN;
   assign accept   = in_valid && in_ready;
   assign mul_done = (state == MUL) && (cnt == CW'(WIDTH));

   always_comb begin
      state_n  = state;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = !out_valid || out_ready;
            if (accept && is_mul) state_n = MUL;
         end
         MUL:  if (mul_done) state_n = HOLD;
         HOLD: if (out_valid && out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         a_sh        <= '0;
         b_sh        <= '0;
         acc         <= '0;
         mtag        <= '0;
         out_valid   <= 1'b0;
         out_result  <= '0;
         out_zero    <= 1'b0;
         out_neg     <= 1'b0;
         out_carry   <= 1'b0;
         out_ovf     <= 1'b0;
         out_illegal <= 1'b0;
         out_tag     <= '0;
      end else begin
         state <= state_n;
         // Loading a new result takes priority over draining the old one.
         if (accept && !is_mul) begin
            out_valid   <= 1'b1;
            out_result  <= res_c;
            out_zero    <= (res_c == '0);
            out_neg     <= res_c[WIDTH-1];
            out_carry   <= carry_c;
            out_ovf     <= ovf_c;
            out_illegal <= ill_c;
            out_tag     <= in_tag;
         end else if (accept && is_mul) begin
            a_sh      <= in_a;
            b_sh      <= in_b;
            acc       <= '0;
            cnt       <= '0;
            mtag      <= in_tag;
            out_valid <= 1'b0;
         end else if (mul_done) begin
            out_valid   <= 1'b1;
            out_result  <= acc;
            out_zero    <= (acc == '0);
            out_neg     <= acc[WIDTH-1];
            out_carry   <= 1'b0;
            out_ovf     <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= mtag;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (state == MUL && !mul_done) begin
            if (b_sh[0]) acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  in_ctl, in_tag, out_tag;
   logic [31:0] in_a, in_b, out_result;
   logic        out_zero, out_neg, out_carry, out_ovf, out_illegal;

   logic        v1_in_valid, v1_in_ready, v1_out_valid, v1_out_ready;
   logic [3:0]  v1_in_ctl, v1_in_tag, v1_out_tag;
   logic [31:0] v1_in_a, v1_in_b, v1_out_result;
   logic        v1_out_zero, v1_out_neg, v1_out_carry, v1_out_ovf, v1_out_illegal;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32), .TAG_W(4), .MUL_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ctl(in_ctl), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
      .out_ovf(out_ovf), .out_illegal(out_illegal), .out_tag(out_tag));

   alu_seq #(.WIDTH(32), .TAG_W(4), .MUL_EN(1'b0)) dut_nomul (
      .clk(clk), .reset(reset), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
      .in_ctl(v1_in_ctl), .in_a(v1_in_a), .in_b(v1_in_b), .in_tag(v1_in_tag),
      .out_valid(v1_out_valid), .out_ready(v1_out_ready), .out_result(v1_out_result),
      .out_zero(v1_out_zero), .out_neg(v1_out_neg), .out_carry(v1_out_carry),
      .out_ovf(v1_out_ovf), .out_illegal(v1_out_illegal), .out_tag(v1_out_tag));

   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] a, b, res;
      logic        z, n, c, o, i;
   } vec_t;

   // {result, zero, neg, carry, ovf, illegal, tag}
   typedef logic [40:0] exp_t;

   exp_t q[$];
   exp_t exp_cur, mon_e;
   vec_t vt[16];
   int   total = 0, bad = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, expv);
      end
   endtask

   function automatic exp_t mk(input vec_t v, input logic [3:0] tag);
      return {v.res, v.z, v.n, v.c, v.o, v.i, tag};
   endfunction

   // Scoreboard: pop/compare completed results, then record newly accepted requests.
   always @(negedge clk) begin
      if (reset) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got tag %0d result %h want no output", out_tag, out_result);
            end else begin
               mon_e = q.pop_front();
               chk("result", 64'({out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal, out_tag}),
                   64'(mon_e));
            end
         end
         if (in_valid && in_ready) q.push_back(exp_cur);
      end
   end

   // Presents one request and returns at posedge+1 of the accepting edge.
   task automatic send(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input exp_t e);
      int n;
      in_ctl   = ctl;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      exp_cur  = e;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 60);
      if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic mul_test(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] tag);
      int k, ir_bad;
      send(4'b1011, a, b, tag, {res, (res == 32'd0), res[31], 1'b0, 1'b0, 1'b0, tag});
      k = 0;
      ir_bad = 0;
      while (!out_valid && k < 60) begin
         if (in_ready) ir_bad++;
         @(posedge clk);
         #1;
         k++;
      end
      chk("mul_latency", 64'(k), 64'(33));
      chk("mul_in_ready_low", 64'(ir_bad), 64'(0));
      chk("mul_hold_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int c0, nv;
      vt[0]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[1]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      vt[2]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{4'b1000, 32'h80000000, 32'h00000021, 32'hC0000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{4'b0101, 32'h80000000, 32'h00000021, 32'h40000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[7]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[10] = '{4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[11] = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[12] = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[13] = '{4'b0110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vt[14] = '{4'b1111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[15] = '{4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_ctl = '0; in_a = '0; in_b = '0; in_tag = '0; exp_cur = '0;
      v1_in_valid = 1'b0; v1_out_ready = 1'b1;
      v1_in_ctl = '0; v1_in_a = '0; v1_in_b = '0; v1_in_tag = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_valid_ready", 64'({out_valid, in_ready}), 64'(2'b01));
      chk("reset_outputs", 64'({out_result, out_zero, out_neg, out_carry, out_ovf, out_illegal, out_tag}), 64'(0));

      // Back-to-back single-cycle ops: one accept per cycle.
      c0 = cyc;
      for (int i = 0; i < 16; i++)
         send(vt[i].ctl, vt[i].a, vt[i].b, 4'(i), mk(vt[i], 4'(i)));
      chk("throughput", 64'(cyc - c0), 64'(16));
      repeat (2) @(posedge clk);
      #1;
      chk("drain_empty", 64'(q.size()), 64'(0));

      mul_test(32'd12345, 32'd6789, 32'd83810205, 4'd5);
      mul_test(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'd6);

      // Backpressure: result held while out_ready is low, next request stalls.
      out_ready = 1'b0;
      send(4'b0010, 32'd10, 32'd20, 4'd1, {32'd30, 5'b00000, 4'd1});
      in_ctl = 4'b0010; in_a = 32'd1; in_b = 32'd2; in_tag = 4'd2;
      exp_cur = {32'd3, 5'b00000, 4'd2};
      in_valid = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("bp_hold", 64'({out_valid, out_result, out_tag, in_ready}), 64'({1'b1, 32'd30, 4'd1, 1'b0}));
      end
      out_ready = 1'b1;
      c0 = cyc;
      send(4'b0010, 32'd1, 32'd2, 4'd2, {32'd3, 5'b00000, 4'd2});
      send(4'b0010, 32'd100, 32'd200, 4'd3, {32'd300, 5'b00000, 4'd3});
      chk("bp_release_rate", 64'(cyc - c0), 64'(2));
      repeat (2) @(posedge clk);
      #1;

      // Reset during the 10th MUL cycle aborts the multiply.
      send(4'b1011, 32'd3, 32'd5, 4'd7, {32'd15, 5'b00000, 4'd7});
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("abort_state", 64'({out_valid, in_ready}), 64'(2'b01));
      nv = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) nv++;
      end
      chk("abort_no_result", 64'(nv), 64'(0));

      // Reset and in_valid together: request dropped.
      reset = 1'b1; in_valid = 1'b1; in_ctl = 4'b0010; in_a = 32'd1; in_b = 32'd1;
      @(posedge clk);
      #1 reset = 1'b0; in_valid = 1'b0;
      chk("reset_wins", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      chk("reset_wins_after", 64'(out_valid), 64'(0));

      // Illegal code after reset.
      send(4'b1111, 32'hDEADBEEF, 32'h1, 4'd9, {32'd0, 5'b10001, 4'd9});
      chk("illegal_direct", 64'({out_valid, out_illegal, out_zero, out_result}), 64'({3'b111, 32'd0}));
      @(posedge clk);
      #1;

      // MUL code with MUL_EN=0 is a one-cycle illegal op.
      v1_in_ctl = 4'b1011; v1_in_a = 32'd3; v1_in_b = 32'd4; v1_in_tag = 4'd4;
      v1_in_valid = 1'b1;
      chk("nomul_ready", 64'(v1_in_ready), 64'(1));
      @(posedge clk);
      #1 v1_in_valid = 1'b0;
      chk("nomul_illegal", 64'({v1_out_valid, v1_out_illegal, v1_out_zero, v1_out_result, v1_out_tag}),
          64'({3'b111, 32'd0, 4'd4}));

      repeat (3) @(posedge clk);
      #1;
      chk("queue_empty", 64'(q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the combinational MIPSALU. It keeps the 4-bit ALUctl encoding and zero flag and adds:
- XOR, shifts, unsigned compare, and an iterative multiply;
- registered outputs with a full flag set;
- valid/ready flow control on both sides.

It sits in the execute stage between operand select and writeback, and tolerates writeback stalls.

Parameters:
WIDTH, 32, operand/result width (>=8, power of two)
TAG_W, 4, width of opaque tag carried from input to output
MUL_EN, 1, 1 = MUL implemented; 0 = MUL code treated as illegal

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept request this cycle
in_ctl  in  4  ALU control code
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B (shift amount = in_b[log2(WIDTH)-1:0])
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  WIDTH  result
out_zero  out  1  out_result == 0
out_neg  out  1  out_result[WIDTH-1]
out_carry  out  1  ADD: carry-out; SUB: carry-out of A+~B+1 (1 = no borrow); else 0
out_ovf  out  1  signed overflow for ADD/SUB; else 0
out_illegal  out  1  in_ctl not a defined code (result forced to 0)
out_tag  out  TAG_W  tag of the request that produced the result

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset.
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SLL; 0101 SRL
  - 0110 SUB; 0111 SLT (signed, result 1/0); 1000 SRA; 1001 SLTU
  - 1011 MUL (low WIDTH bits of A*B); 1100 NOR
  - All other codes are illegal. MUL is also illegal when MUL_EN=0.
- Arithmetic: mod 2^WIDTH. Shifts use only the low log2(WIDTH) bits of in_b.
- FSM states: IDLE, MUL, HOLD.
  - IDLE: in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready.
  - Non-MUL accept: the result and all flags are registered on the same edge, out_valid=1 next cycle (1-cycle latency). Stay in IDLE, so back-to-back accepts give 1 result/cycle when out_ready=1.
  - MUL accept: latch A, B, tag, clear accumulator, counter=0, go to MUL. out_valid falls on that edge if the old result is drained.
  - MUL: in_ready=0. Each cycle: if B_shift[0], acc += A_shift; then A_shift <<= 1, B_shift >>= 1, counter++. After WIDTH iterations, load the output register with acc, set out_valid=1 and go to HOLD.
  - HOLD: in_ready=0 until out_ready && out_valid, then return to IDLE. MUL latency = WIDTH+1 edges from accept to out_valid.
- Output register: holds stable while out_valid && !out_ready. All outputs (result, flags, tag) change only on accept/complete.
- Drain rule: out_valid clears on an out_ready handshake unless a new result is loaded on the same edge; a new result wins.
- Flags for MUL/logic/shift/SLT: carry=0, ovf=0, zero/neg computed from the result.
- Illegal code: accepted like a 1-cycle op; result=0, zero=1, illegal=1.
- Reset: out_valid=0, out_result=0, all flags 0, out_tag=0, state=IDLE, counter=0.
  - Reset mid-MUL aborts the operation; no result is produced.
  - in_ready=1 in the first cycle after reset deasserts.
- Simultaneous reset and in_valid: reset wins; the request is not accepted.

Test Plan:
- WIDTH=32; in_ctl=0010, A=0xFFFFFFFF, B=1, out_ready=1 -> next cycle out_valid=1, result=0, zero=1, carry=1, ovf=0.
- in_ctl=0110, A=0x80000000, B=1 -> result 0x7FFFFFFF, ovf=1, carry=1, neg=0. Then SLT with A=0xFFFFFFFF, B=1 -> result 1; SLTU with the same operands -> result 0.
- Shifts with A=0x80000000: SRA with B=0x21 (amount 1) -> 0xC0000000; SRL -> 0x40000000; SLL with A=1, B=31 -> 0x80000000.
- MUL A=12345, B=6789 -> out_valid exactly 33 edges after accept, result 83810205, in_ready=0 throughout. Also A=0xFFFFFFFF, B=0xFFFFFFFF -> result 1.
- Backpressure: hold out_ready=0 while 3 ADDs are offered -> first ADD accepted, result held stable, in_ready=0, remaining two not accepted. Raise out_ready -> accepted one per cycle with matching out_tag 1,2,3.
- Reset asserted in 10th MUL cycle -> next cycle out_valid=0, in_ready=1. Then in_ctl=1111 -> result 0, illegal=1, zero=1. With MUL_EN=0, in_ctl=1011 -> illegal=1 after 1 cycle.
